usr_deser: RTL and testbench

USR_DESER -- requirements
Module: usr_deser

---
 rtl/usr_deser.sv | 114 +++++++++++
 tb/tb_usr_deser.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/usr_deser.sv
// usr_deser: UART-style deserializer (start, W data bits, [even parity], stop) into a holding register with v/a handshake.
// Latency: v rises one edge after the stop strobe. Backpressure: completion while v=1 and a=0 drops the word and sets sticky ov.
// Optional parity stage: define USR_DESER_PARITY_EN.
module usr_deser #(
   parameter int W = 4
) (
   input  logic         c,
   input  logic         r,
   input  logic         z,
   input  logic         e,
   input  logic         d,
   input  logic         a,
   output logic [W-1:0] y,
   output logic         v,
   output logic         fe,
   output logic         ov,
   output logic         pe
);

   localparam int CW = $clog2(W + 1);

`ifdef USR_DESER_PARITY_EN
   typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

   state_t          state;
   state_t          state_nxt;
   logic [W-1:0]    sr;
   logic [CW-1:0]   cnt;
   logic            dir;
   logic            last_bit;
   logic            par_err;
   logic            done;

   assign last_bit = (cnt == CW'(W - 1));

   always_ff @(posedge c or negedge r) begin
      if (!r) state <= IDLE;
      else    state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         IDLE: if (e && !z) state_nxt = DATA;
`ifdef USR_DESER_PARITY_EN
         DATA: if (e && last_bit) state_nxt = PAR;
         PAR:  if (e) state_nxt = STOP;
`else
         DATA: if (e && last_bit) state_nxt = STOP;
`endif
         STOP: begin
            if (e) begin
               state_nxt = IDLE;
               done      = z && !par_err;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bit order is latched at the start bit so d may change mid-frame.
   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         sr  <= '0;
         cnt <= '0;
         dir <= 1'b0;
         y   <= '0;
         v   <= 1'b0;
         fe  <= 1'b0;
         ov  <= 1'b0;
      end else begin
         fe <= (state == STOP) && e && !z;
         if (state == IDLE && e && !z) begin
            cnt <= '0;
            dir <= d;
         end
         if (state == DATA && e) begin
            sr  <= dir ? {sr[W-2:0], z} : {z, sr[W-1:1]};
            cnt <= cnt + 1'b1;
         end
         if (done) begin
            if (!v || a) begin
               y <= sr;
               v <= 1'b1;
            end else begin
               ov <= 1'b1;
            end
         end else if (a && v) begin
            v <= 1'b0;
         end
      end
   end

`ifdef USR_DESER_PARITY_EN
   always_ff @(posedge c or negedge r) begin
      if (!r) begin
         par_err <= 1'b0;
         pe      <= 1'b0;
      end else begin
         if (state == PAR && e) par_err <= (^sr) ^ z;
         // A bad stop bit reports fe only.
         pe <= (state == STOP) && e && z && par_err;
      end
   end
`else
   assign par_err = 1'b0;
   assign pe      = 1'b0;
`endif

endmodule

// File: tb/tb_usr_deser.sv
// Bench for usr_deser with W=4 and a strobe every other cycle; reference model tracks y/v/ov/fe per frame.
module tb_usr_deser;
   localparam int W = 4;

   logic         c, r, z, e, d, a;
   logic [W-1:0] y;
   logic         v, fe, ov, pe;

   int checks = 0;
   int errors = 0;

   logic [W-1:0] m_y;
   logic         m_v, m_ov, m_fe;

   usr_deser #(.W(W)) dut (
      .c(c), .r(r), .z(z), .e(e), .d(d), .a(a),
      .y(y), .v(v), .fe(fe), .ov(ov), .pe(pe)
   );

   initial c = 1'b0;
   always #5 c = ~c;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // i-th transmitted bit goes to y[i] (d=0) or y[W-1-i] (d=1)
   function automatic logic [W-1:0] word_of(input logic [W-1:0] bits, input logic dir);
      logic [W-1:0] w;
      for (int i = 0; i < W; i++) w[dir ? (W - 1 - i) : i] = bits[i];
      return w;
   endfunction

   task automatic strobe(input logic b, input logic acc);
      @(negedge c); z = b; e = 1'b1; a = acc;
      @(posedge c);
      @(negedge c); e = 1'b0; a = 1'b0;
   endtask

   task automatic send_frame(input logic [W-1:0] bits, input logic dir, input logic stop,
                             input logic acc, input logic tog);
      d = dir;
      strobe(1'b0, 1'b0);
      for (int i = 0; i < W; i++) begin
         strobe(bits[i], 1'b0);
         if (tog) d = ~d;
      end
`ifdef USR_DESER_PARITY_EN
      strobe(^bits, 1'b0);
`endif
      strobe(stop, acc);
      m_fe = !stop;
      if (stop) begin
         if (!m_v || acc) begin
            m_y = word_of(bits, dir);
            m_v = 1'b1;
         end else begin
            m_ov = 1'b1;
         end
      end else if (acc && m_v) begin
         m_v = 1'b0;
      end
   endtask

   task automatic accept_cycle();
      @(negedge c); a = 1'b1;
      @(posedge c);
      @(negedge c); a = 1'b0;
      m_v = 1'b0;
   endtask

   task automatic test_reset();
      r = 1'b0; z = 1'b1; e = 1'b0; d = 1'b0; a = 1'b0;
      m_y = '0; m_v = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
      #1;
      checks++; if (y !== 4'b0000) begin errors++; $display("FAIL reset_y got=%b exp=0000", y); end
      checks++; if (v !== 1'b0)    begin errors++; $display("FAIL reset_v got=%b exp=0", v); end
      checks++; if ({fe, ov, pe} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {fe, ov, pe}); end
      repeat (2) @(negedge c);
      r = 1'b1;
   endtask

   task automatic test_basic();
      send_frame(4'b1010, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (y !== 4'b1010) begin errors++; $display("FAIL basic_y got=%b exp=1010", y); end
      checks++; if (v !== 1'b1)    begin errors++; $display("FAIL basic_v got=%b exp=1", v); end
      repeat (3) @(negedge c);
      checks++; if (v !== 1'b1 || y !== 4'b1010) begin errors++; $display("FAIL basic_hold got=%b/%b exp=1/1010", v, y); end
      accept_cycle();
      checks++; if (v !== 1'b0)    begin errors++; $display("FAIL basic_accept_v got=%b exp=0", v); end
      checks++; if (y !== 4'b1010) begin errors++; $display("FAIL basic_accept_y got=%b exp=1010", y); end
      accept_cycle();
      checks++; if (v !== 1'b0 || y !== 4'b1010) begin errors++; $display("FAIL accept_idle got=%b/%b exp=0/1010", v, y); end
   endtask

   task automatic test_order();
      send_frame(4'b1010, 1'b1, 1'b1, 1'b0, 1'b1);
      checks++; if (y !== 4'b0101 || v !== 1'b1) begin errors++; $display("FAIL order_msb got=%b/%b exp=0101/1", y, v); end
      accept_cycle();
   endtask

   task automatic test_framing();
      send_frame(4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (fe !== 1'b1) begin errors++; $display("FAIL fe_pulse got=%b exp=1", fe); end
      checks++; if (v !== 1'b0)  begin errors++; $display("FAIL fe_v got=%b exp=0", v); end
      @(negedge c);
      checks++; if (fe !== 1'b0) begin errors++; $display("FAIL fe_width got=%b exp=0", fe); end
      send_frame(4'b0011, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (y !== 4'b0011 || v !== 1'b1) begin errors++; $display("FAIL fe_next got=%b/%b exp=0011/1", y, v); end
      accept_cycle();
   endtask

   task automatic test_overrun();
      send_frame(4'b1010, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(4'b0011, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ov_set got=%b exp=1", ov); end
      checks++; if (y !== 4'b1010 || v !== 1'b1) begin errors++; $display("FAIL ov_keep got=%b/%b exp=1010/1", y, v); end
      accept_cycle();
      repeat (3) @(negedge c);
      checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ov_sticky got=%b exp=1", ov); end
   endtask

   task automatic test_mid_reset();
      d = 1'b0;
      strobe(1'b0, 1'b0);
      strobe(1'b1, 1'b0);
      strobe(1'b0, 1'b0);
      #2 r = 1'b0;
      #1;
      checks++; if (y !== 4'b0000 || v !== 1'b0) begin errors++; $display("FAIL midrst_yv got=%b/%b exp=0000/0", y, v); end
      checks++; if ({fe, ov} !== 2'b00) begin errors++; $display("FAIL midrst_flags got=%b exp=00", {fe, ov}); end
      m_y = '0; m_v = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
      @(negedge c); r = 1'b1;
      send_frame(4'b0011, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (y !== 4'b0011 || v !== 1'b1) begin errors++; $display("FAIL midrst_next got=%b/%b exp=0011/1", y, v); end
      accept_cycle();
   endtask

   task automatic test_back_to_back();
      send_frame(4'b1010, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(4'b1100, 1'b0, 1'b1, 1'b1, 1'b0);
      checks++; if (y !== 4'b1100 || v !== 1'b1) begin errors++; $display("FAIL b2b_load got=%b/%b exp=1100/1", y, v); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL b2b_ov got=%b exp=0", ov); end
      accept_cycle();
   endtask

`ifdef USR_DESER_PARITY_EN
   task automatic test_parity();
      d = 1'b0;
      strobe(1'b0, 1'b0);
      for (int i = 0; i < W; i++) strobe(i[0], 1'b0);
      strobe(1'b1, 1'b0);
      strobe(1'b1, 1'b0);
      checks++; if (pe !== 1'b1 || v !== 1'b0) begin errors++; $display("FAIL par_bad got=%b/%b exp=1/0", pe, v); end
      @(negedge c);
      checks++; if (pe !== 1'b0) begin errors++; $display("FAIL par_width got=%b exp=0", pe); end
      strobe(1'b0, 1'b0);
      for (int i = 0; i < W; i++) strobe(i[0], 1'b0);
      strobe(1'b0, 1'b0);
      strobe(1'b1, 1'b0);
      checks++; if (y !== 4'b1010 || v !== 1'b1 || pe !== 1'b0) begin errors++; $display("FAIL par_good got=%b/%b/%b exp=1010/1/0", y, v, pe); end
      m_y = 4'b1010; m_v = 1'b1;
      accept_cycle();
   endtask
`endif

   task automatic test_random();
      logic [W-1:0] bits;
      logic dir, stop, acc;
      for (int n = 0; n < 40; n++) begin
         bits = W'($urandom);
         dir  = 1'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         acc  = 1'($urandom);
         send_frame(bits, dir, stop, acc, 1'($urandom));
         checks++;
         if ({y, v, ov, fe, pe} !== {m_y, m_v, m_ov, m_fe, 1'b0}) begin
            errors++;
            $display("FAIL rand_%0d got y=%b v=%b ov=%b fe=%b pe=%b exp y=%b v=%b ov=%b fe=%b pe=0",
                     n, y, v, ov, fe, pe, m_y, m_v, m_ov, m_fe);
         end
         if ($urandom_range(0, 2) == 0) accept_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_order();
      test_framing();
      test_overrun();
      test_mid_reset();
      test_back_to_back();
`ifdef USR_DESER_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
